// File: rtl/fft_pkg.sv
// Shared FFT types and defaults, used by the FFT datapath, the frame loader and the bench.
package fft_pkg;

   localparam int FFT_N = 16;
   localparam int FFT_W = 31;
   localparam int Q     = 16;

   typedef logic signed [FFT_W:0] sample_t;
   typedef sample_t [1:0]         cplx_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One ping-pong bank: N-entry sample store with fill count, full/padded flags and a
// parallel read that masks everything at or beyond the fill count to zero.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int N = FFT_N,
   parameter int W = FFT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_wr_en,
   input  logic                    i_wr_last,
   input  logic [W:0]              i_wr_re,
   input  logic [W:0]              i_wr_im,
   input  logic                    i_rd_clr,
   output logic                    o_close,
   output logic                    o_full,
   output logic                    o_padded,
   output logic [N-1:0][1:0][W:0]  o_x
);

   localparam int AW = $clog2(N);
   localparam int CW = $clog2(N + 1);

   logic [CW-1:0]           r_cnt;
   logic                    r_full;
   logic                    r_padded;
   logic [N-1:0][1:0][W:0]  r_mem;
   logic [AW-1:0]           w_idx;

   assign w_idx    = r_cnt[AW-1:0];
   assign o_close  = i_wr_en & (i_wr_last | (r_cnt == CW'(N - 1)));
   assign o_full   = r_full;
   assign o_padded = r_padded;

   // Writes and consumption never target the same bank in one cycle: a full bank refuses writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_full   <= 1'b0;
         r_padded <= 1'b0;
      end else if (i_wr_en) begin
         r_cnt <= r_cnt + 1'b1;
         if (o_close) begin
            r_full   <= 1'b1;
            r_padded <= (r_cnt != CW'(N - 1));
         end
      end else if (i_rd_clr) begin
         r_cnt    <= '0;
         r_full   <= 1'b0;
         r_padded <= 1'b0;
      end
   end

   // Storage is never cleared; the fill count alone hides stale entries.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[w_idx] <= {i_wr_im, i_wr_re};
      end
   end

   always_comb begin
      o_x = '0;
      for (int k = 0; k < N; k++) begin
         if (CW'(k) < r_cnt) begin
            o_x[k] = r_mem[k];
         end
      end
   end

endmodule

// File: rtl/fft_frame_loader.sv
// Streaming-to-parallel framer for the combinational FFT: two banks in ping-pong,
// a write pointer for the filling bank and a read pointer for the presented frame.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int N = FFT_N,
   parameter int W = FFT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [W:0]              s_re,
   input  logic [W:0]              s_im,
   input  logic                    s_last,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [N-1:0][1:0][W:0]  frame_x,
   output logic                    frame_padded,
   output logic                    frame_overrun
);

   logic                          r_wb;
   logic                          r_rb;
   logic [1:0]                    w_full;
   logic [1:0]                    w_padded;
   logic [1:0]                    w_close;
   logic [1:0]                    w_wr_en;
   logic [1:0]                    w_rd_clr;
   logic [1:0][N-1:0][1:0][W:0]   w_x;
   logic                          w_accept;
   logic                          w_consume;

   // The write bank is full only when the other bank is full too.
   assign s_ready       = !w_full[r_wb];
   assign w_accept      = s_valid & s_ready;
   assign frame_valid   = w_full[r_rb];
   assign w_consume     = frame_valid & frame_ready;
   assign frame_padded  = w_padded[r_rb];
   assign frame_x       = w_x[r_rb];
   assign frame_overrun = 1'b0;

   for (genvar g = 0; g < 2; g++) begin : g_bank
      assign w_wr_en[g]  = w_accept  & (r_wb == 1'(g));
      assign w_rd_clr[g] = w_consume & (r_rb == 1'(g));

      fft_frame_bank #(
         .N (N),
         .W (W)
      ) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_wr_en   (w_wr_en[g]),
         .i_wr_last (s_last),
         .i_wr_re   (s_re),
         .i_wr_im   (s_im),
         .i_rd_clr  (w_rd_clr[g]),
         .o_close   (w_close[g]),
         .o_full    (w_full[g]),
         .o_padded  (w_padded[g]),
         .o_x       (w_x[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wb <= 1'b0;
         r_rb <= 1'b0;
      end else begin
         if (|w_close) begin
            r_wb <= ~r_wb;
         end
         if (w_consume) begin
            r_rb <= ~r_rb;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a frame-queue reference model.
module tb_fft_frame_loader;
   import fft_pkg::*;

   localparam int N = FFT_N;
   localparam int W = FFT_W;

   typedef logic [N-1:0][1:0][W:0] frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [W:0]  s_re = '0;
   logic [W:0]  s_im = '0;
   logic        s_last = 1'b0;
   logic        frame_valid;
   logic        frame_ready = 1'b0;
   frame_t      frame_x;
   logic        frame_padded;
   logic        frame_overrun;

   int          checkCount = 0;
   int          errorCount = 0;
   int          dutAccepts = 0;

   // Reference model: completed-but-unconsumed frames plus the frame being assembled.
   frame_t      expQ[$];
   bit          padQ[$];
   frame_t      curFrame = '0;
   int          curCnt = 0;

   always #5 clk = ~clk;

   fft_frame_loader #(
      .N (N),
      .W (W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_re          (s_re),
      .s_im          (s_im),
      .s_last        (s_last),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .frame_x       (frame_x),
      .frame_padded  (frame_padded),
      .frame_overrun (frame_overrun)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One cycle: check outputs at the negedge, drive inputs, advance the model.
   task automatic applyStimulus(input logic v, input logic [W:0] re, input logic [W:0] im,
                                input logic last, input logic fr);
      bit expReady;
      bit expValid;
      @(negedge clk);
      expReady = (expQ.size() < 2);
      expValid = (expQ.size() > 0);
      checkOutput("s_ready", 64'(s_ready), 64'(expReady));
      checkOutput("frame_valid", 64'(frame_valid), 64'(expValid));
      checkOutput("frame_overrun", 64'(frame_overrun), 64'd0);
      if (expValid) begin
         checkOutput("frame_padded", 64'(frame_padded), 64'(padQ[0]));
         for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("re[%0d]", k), 64'(frame_x[k][0]), 64'(expQ[0][k][0]));
            checkOutput($sformatf("im[%0d]", k), 64'(frame_x[k][1]), 64'(expQ[0][k][1]));
         end
      end
      s_valid     = v;
      s_re        = re;
      s_im        = im;
      s_last      = last;
      frame_ready = fr;
      if (s_valid && s_ready) dutAccepts++;
      if (expValid && fr) begin
         void'(expQ.pop_front());
         void'(padQ.pop_front());
      end
      if (v && expReady) begin
         curFrame[curCnt] = {im, re};
         curCnt++;
         if (last || curCnt == N) begin
            expQ.push_back(curFrame);
            padQ.push_back(curCnt < N);
            curFrame = '0;
            curCnt   = 0;
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n       = 1'b0;
      s_valid     = 1'b0;
      s_last      = 1'b0;
      frame_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
      checkOutput("rst_frame_valid", 64'(frame_valid), 64'd0);
      checkOutput("rst_frame_padded", 64'(frame_padded), 64'd0);
      checkOutput("rst_frame_overrun", 64'(frame_overrun), 64'd0);
      for (int k = 0; k < N; k++) begin
         checkOutput($sformatf("rst_x[%0d]", k), 64'(frame_x[k]), 64'd0);
      end
      rst_n = 1'b1;
      expQ.delete();
      padQ.delete();
      curFrame = '0;
      curCnt   = 0;
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic ramp(input bit fr);
      logic [W:0] v;
      for (int k = 0; k < N; k++) begin
         v = (W+1)'(k) << Q;
         applyStimulus(1'b1, v, '0, k == N - 1, fr);
      end
   endtask

   initial begin
      doReset();

      // Ramp, twice, so the following short frame lands in a bank that held ramp data.
      ramp(1'b1);
      ramp(1'b1);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, (W+1)'(65536), '0, k == 4, 1'b1);
      drain(4);

      // Backpressure: only two frames fit, then one consume reopens the stream.
      dutAccepts = 0;
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, 1'b0);
      checkOutput("bp_accepts", 64'(dutAccepts), 64'd32);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      drain(4);

      // Frame B closes in the same cycle frame A is consumed.
      for (int i = 0; i < N; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < N; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, i == N - 1);
      drain(4);

      // Reset mid-frame discards the partial frame.
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, 1'b1);
      doReset();
      for (int i = 0; i < N; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, 1'b1);
      drain(4);

      // No s_last: back-to-back full frames.
      for (int i = 0; i < 3 * N; i++) applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b0, 1'b1);
      drain(4);

      // Single-sample frame.
      applyStimulus(1'b1, (W+1)'($urandom), (W+1)'($urandom), 1'b1, 1'b0);
      drain(3);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, (W+1)'($urandom), (W+1)'($urandom),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      end
      drain(6);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
